// File: rtl/issue_stage_pkg.sv
// Shared widths, opcode constants and buffer state encoding for the issue stage.
// Widths match the register file that sits downstream.
package issue_stage_pkg;

  localparam int W_OPR = 32;
  localparam int W_RD  = 4;
  localparam int W_OP  = 6;
  localparam int W_CNT = 16;

  localparam logic [W_OP-1:0] OP_ADD = 6'h01;
  localparam logic [W_OP-1:0] OP_SUB = 6'h02;
  localparam logic [W_OP-1:0] OP_AND = 6'h03;
  localparam logic [W_OP-1:0] OP_OR  = 6'h04;
  localparam logic [W_OP-1:0] OP_XOR = 6'h05;
  localparam logic [W_OP-1:0] OP_MOV = 6'h06;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/issue_stage_buf.sv
// One-entry valid/ready output register feeding execute.
// Data fields only change on load; a drain clears valid alone.
module issue_buf #(
  parameter int W_OPR = issue_stage_pkg::W_OPR,
  parameter int W_RD  = issue_stage_pkg::W_RD,
  parameter int W_OP  = issue_stage_pkg::W_OP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             ready_i,
  input  logic [W_OP-1:0]  op_i,
  input  logic [W_RD-1:0]  rd_i,
  input  logic             we_i,
  input  logic [W_OPR-1:0] opr0_i,
  input  logic [W_OPR-1:0] opr1_i,
  output logic             valid_o,
  output logic             slot_free_o,
  output logic [W_OP-1:0]  op_o,
  output logic [W_RD-1:0]  rd_o,
  output logic             we_o,
  output logic [W_OPR-1:0] opr0_o,
  output logic [W_OPR-1:0] opr1_o
);
  import issue_stage_pkg::*;

  buf_state_e       state_q, state_d;
  logic [W_OP-1:0]  op_q, op_d;
  logic [W_RD-1:0]  rd_q, rd_d;
  logic             we_q, we_d;
  logic [W_OPR-1:0] opr0_q, opr0_d;
  logic [W_OPR-1:0] opr1_q, opr1_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BUF_EMPTY;
      op_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      opr0_q  <= '0;
      opr1_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      opr0_q  <= opr0_d;
      opr1_q  <= opr1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    we_d    = we_q;
    opr0_d  = opr0_q;
    opr1_d  = opr1_q;
    unique case (state_q)
      BUF_EMPTY: if (load_i) state_d = BUF_FULL;
      BUF_FULL:  if (ready_i && !load_i) state_d = BUF_EMPTY;
    endcase
    if (load_i) begin
      op_d   = op_i;
      rd_d   = rd_i;
      we_d   = we_i;
      opr0_d = opr0_i;
      opr1_d = opr1_i;
    end
  end

  assign valid_o     = (state_q == BUF_FULL);
  assign slot_free_o = !valid_o || ready_i;
  assign op_o        = op_q;
  assign rd_o        = rd_q;
  assign we_o        = we_q;
  assign opr0_o      = opr0_q;
  assign opr1_o      = opr1_q;

endmodule

// File: rtl/issue_stage.sv
// Operand-fetch / issue stage: RF index muxing, reservation check,
// reserve strobe, hazard-stall counter and the output buffer.
module issue_stage #(
  parameter int W_OPR = issue_stage_pkg::W_OPR,
  parameter int W_RD  = issue_stage_pkg::W_RD,
  parameter int W_OP  = issue_stage_pkg::W_OP,
  parameter int W_CNT = issue_stage_pkg::W_CNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid_i,
  output logic             dec_ready_o,
  input  logic [W_OP-1:0]  dec_op_i,
  input  logic [W_RD-1:0]  dec_rd_i,
  input  logic [W_RD-1:0]  dec_rs_i,
  input  logic             dec_we_i,
  input  logic             dec_use_imm_i,
  input  logic [W_OPR-1:0] dec_imm_i,
  output logic [W_RD-1:0]  rf_r0_o,
  output logic [W_RD-1:0]  rf_r1_o,
  output logic             rf_w_reserve_o,
  input  logic [W_OPR-1:0] rf_opr0_i,
  input  logic [W_OPR-1:0] rf_opr1_i,
  input  logic             rf_reserved_i,
  output logic             ex_valid_o,
  input  logic             ex_ready_i,
  output logic [W_OP-1:0]  ex_op_o,
  output logic [W_RD-1:0]  ex_rd_o,
  output logic             ex_we_o,
  output logic [W_OPR-1:0] ex_opr0_o,
  output logic [W_OPR-1:0] ex_opr1_o,
  output logic [W_CNT-1:0] stall_cnt_o
);
  import issue_stage_pkg::*;

  logic             slot_free;
  logic             fire;
  logic             hazard;
  logic [W_OPR-1:0] opr1;
  logic [W_CNT-1:0] cnt_q, cnt_d;

  // An immediate op aliases r1 onto rd so an unused rs cannot stall.
  assign rf_r0_o = dec_rd_i;
  assign rf_r1_o = dec_use_imm_i ? dec_rd_i : dec_rs_i;

  assign dec_ready_o    = !rf_reserved_i && slot_free;
  assign fire           = dec_valid_i && dec_ready_o;
  assign rf_w_reserve_o = fire && dec_we_i;
  assign opr1           = dec_use_imm_i ? dec_imm_i : rf_opr1_i;

  // Only register hazards count; backpressure stalls do not.
  assign hazard = dec_valid_i && rf_reserved_i && slot_free;

  always_comb begin
    cnt_d = cnt_q;
    if (hazard && !(&cnt_q)) cnt_d = cnt_q + W_CNT'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_cnt_o = cnt_q;

  issue_buf #(
    .W_OPR(W_OPR),
    .W_RD (W_RD),
    .W_OP (W_OP)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .load_i     (fire),
    .ready_i    (ex_ready_i),
    .op_i       (dec_op_i),
    .rd_i       (dec_rd_i),
    .we_i       (dec_we_i),
    .opr0_i     (rf_opr0_i),
    .opr1_i     (opr1),
    .valid_o    (ex_valid_o),
    .slot_free_o(slot_free),
    .op_o       (ex_op_o),
    .rd_o       (ex_rd_o),
    .we_o       (ex_we_o),
    .opr0_o     (ex_opr0_o),
    .opr1_o     (ex_opr1_o)
  );

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: RF reservation model plus an expected-output queue.
module tb_issue_stage;
  import issue_stage_pkg::*;

  typedef struct packed {
    logic [5:0]  op;
    logic [3:0]  rd;
    logic        we;
    logic [31:0] o0;
    logic [31:0] o1;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        dec_valid_i = 1'b0;
  logic        dec_ready_o;
  logic [5:0]  dec_op_i = '0;
  logic [3:0]  dec_rd_i = '0;
  logic [3:0]  dec_rs_i = '0;
  logic        dec_we_i = 1'b0;
  logic        dec_use_imm_i = 1'b0;
  logic [31:0] dec_imm_i = '0;
  logic [3:0]  rf_r0_o, rf_r1_o;
  logic        rf_w_reserve_o;
  logic [31:0] rf_opr0_i, rf_opr1_i;
  logic        rf_reserved_i;
  logic        ex_valid_o;
  logic        ex_ready_i = 1'b0;
  logic [5:0]  ex_op_o;
  logic [3:0]  ex_rd_o;
  logic        ex_we_o;
  logic [31:0] ex_opr0_o, ex_opr1_o;
  logic [15:0] stall_cnt_o;

  logic        s_ready, s_rsv, s_valid, s_we;
  logic [3:0]  s_r0, s_r1, s_rd;
  logic [5:0]  s_op;
  logic [31:0] s_o0, s_o1;
  logic [3:0]  s_cnt;

  issue_stage dut (
    .clk(clk), .reset(reset),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_op_i(dec_op_i), .dec_rd_i(dec_rd_i), .dec_rs_i(dec_rs_i),
    .dec_we_i(dec_we_i), .dec_use_imm_i(dec_use_imm_i), .dec_imm_i(dec_imm_i),
    .rf_r0_o(rf_r0_o), .rf_r1_o(rf_r1_o), .rf_w_reserve_o(rf_w_reserve_o),
    .rf_opr0_i(rf_opr0_i), .rf_opr1_i(rf_opr1_i), .rf_reserved_i(rf_reserved_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_op_o(ex_op_o), .ex_rd_o(ex_rd_o), .ex_we_o(ex_we_o),
    .ex_opr0_o(ex_opr0_o), .ex_opr1_o(ex_opr1_o), .stall_cnt_o(stall_cnt_o)
  );

  issue_stage #(.W_CNT(4)) dut_sat (
    .clk(clk), .reset(reset),
    .dec_valid_i(dec_valid_i), .dec_ready_o(s_ready),
    .dec_op_i(dec_op_i), .dec_rd_i(dec_rd_i), .dec_rs_i(dec_rs_i),
    .dec_we_i(dec_we_i), .dec_use_imm_i(dec_use_imm_i), .dec_imm_i(dec_imm_i),
    .rf_r0_o(s_r0), .rf_r1_o(s_r1), .rf_w_reserve_o(s_rsv),
    .rf_opr0_i(rf_opr0_i), .rf_opr1_i(rf_opr1_i), .rf_reserved_i(rf_reserved_i),
    .ex_valid_o(s_valid), .ex_ready_i(ex_ready_i),
    .ex_op_o(s_op), .ex_rd_o(s_rd), .ex_we_o(s_we),
    .ex_opr0_o(s_o0), .ex_opr1_o(s_o1), .stall_cnt_o(s_cnt)
  );

  // Register file model with reservation bits; writeback clears at the edge.
  logic [31:0] regs [16];
  logic [15:0] res;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_idx = '0;
  logic [31:0] wb_data = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      res <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= 32'h1000 + i;
      regs[3] <= 32'h10;
      regs[5] <= 32'h20;
    end else begin
      if (wb_en) begin
        regs[wb_idx] <= wb_data;
        res[wb_idx]  <= 1'b0;
      end
      if (rf_w_reserve_o) res[rf_r0_o] <= 1'b1;
    end
  end

  assign rf_reserved_i = res[rf_r0_o] | res[rf_r1_o];
  assign rf_opr0_i     = regs[rf_r0_o];
  assign rf_opr1_i     = regs[rf_r1_o];

  exp_t got;
  assign got = {ex_op_o, ex_rd_o, ex_we_o, ex_opr0_o, ex_opr1_o};

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(input logic [5:0] op, input logic [3:0] rd,
                              input logic we, input logic [31:0] a,
                              input logic [31:0] b);
    return {op, rd, we, a, b};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [3:0] rd,
                       input logic [3:0] rs, input logic we,
                       input logic ui, input logic [31:0] imm);
    dec_valid_i   = 1'b1;
    dec_op_i      = op;
    dec_rd_i      = rd;
    dec_rs_i      = rs;
    dec_we_i      = we;
    dec_use_imm_i = ui;
    dec_imm_i     = imm;
  endtask

  task automatic wb(input logic [3:0] idx, input logic [31:0] d);
    wb_en   = 1'b1;
    wb_idx  = idx;
    wb_data = d;
    step;
    wb_en = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (ex_valid_o !== 1'b0 || stall_cnt_o !== 16'd0 || got !== '0 || s_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_vals: v=%b cnt=%h out=%h exp 0", ex_valid_o, stall_cnt_o, got);
    end
    @(negedge clk);
    reset = 1'b0;
    step;
  endtask

  task automatic test_add;
    exp_t e;
    ex_ready_i = 1'b1;
    drive(OP_ADD, 4'd3, 4'd5, 1'b1, 1'b0, 32'h0);
    #1;
    checks++;
    if (dec_ready_o !== 1'b1 || rf_w_reserve_o !== 1'b1 || rf_r0_o !== 4'd3 || rf_r1_o !== 4'd5) begin
      errors++;
      $display("FAIL add_fire: rdy=%b rsv=%b r0=%0d r1=%0d exp 1 1 3 5",
               dec_ready_o, rf_w_reserve_o, rf_r0_o, rf_r1_o);
    end
    sbq.push_back(mk(OP_ADD, 4'd3, 1'b1, 32'h10, 32'h20));
    step;
    dec_valid_i = 1'b0;
    #1;
    checks++;
    if (rf_w_reserve_o !== 1'b0) begin
      errors++;
      $display("FAIL add_rsv_pulse: rsv=%b exp 0", rf_w_reserve_o);
    end
    if (sbq.size() != 0) e = sbq.pop_front(); else e = '1;
    checks++;
    if (ex_valid_o !== 1'b1 || got !== e) begin
      errors++;
      $display("FAIL add_out: v=%b got=%h exp=%h", ex_valid_o, got, e);
    end
    step;
    checks++;
    if (ex_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL add_drain: v=%b exp 0", ex_valid_o);
    end
    wb(4'd3, 32'h33);
  endtask

  task automatic test_imm;
    exp_t e;
    logic [15:0] s0;
    s0 = stall_cnt_o;
    drive(OP_MOV, 4'd7, 4'd0, 1'b1, 1'b0, 32'h0);
    sbq.push_back(mk(OP_MOV, 4'd7, 1'b1, 32'h1007, 32'h1000));
    step;
    if (sbq.size() != 0) e = sbq.pop_front(); else e = '1;
    checks++;
    if (ex_valid_o !== 1'b1 || got !== e) begin
      errors++;
      $display("FAIL imm_writer_out: v=%b got=%h exp=%h", ex_valid_o, got, e);
    end
    drive(OP_ADD, 4'd2, 4'd7, 1'b1, 1'b1, 32'hFFFF_FFF0);
    #1;
    checks++;
    if (dec_ready_o !== 1'b1 || rf_r1_o !== 4'd2 || rf_w_reserve_o !== 1'b1) begin
      errors++;
      $display("FAIL imm_fire: rdy=%b r1=%0d rsv=%b exp 1 2 1",
               dec_ready_o, rf_r1_o, rf_w_reserve_o);
    end
    sbq.push_back(mk(OP_ADD, 4'd2, 1'b1, 32'h1002, 32'hFFFF_FFF0));
    step;
    dec_valid_i = 1'b0;
    if (sbq.size() != 0) e = sbq.pop_front(); else e = '1;
    checks++;
    if (ex_valid_o !== 1'b1 || got !== e) begin
      errors++;
      $display("FAIL imm_out: v=%b got=%h exp=%h", ex_valid_o, got, e);
    end
    checks++;
    if (stall_cnt_o !== s0) begin
      errors++;
      $display("FAIL imm_nostall: cnt=%0d exp %0d", stall_cnt_o, s0);
    end
    step;
    wb(4'd7, 32'h77);
    wb(4'd2, 32'h22);
  endtask

  task automatic test_dependent;
    exp_t e;
    logic [15:0] s0;
    logic [15:0] d;
    s0 = stall_cnt_o;
    drive(OP_ADD, 4'd4, 4'd1, 1'b1, 1'b0, 32'h0);
    sbq.push_back(mk(OP_ADD, 4'd4, 1'b1, 32'h1004, 32'h1001));
    step;
    if (sbq.size() != 0) e = sbq.pop_front(); else e = '1;
    checks++;
    if (ex_valid_o !== 1'b1 || got !== e) begin
      errors++;
      $display("FAIL dep_a_out: v=%b got=%h exp=%h", ex_valid_o, got, e);
    end
    drive(OP_SUB, 4'd6, 4'd4, 1'b1, 1'b0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin
        wb_en   = 1'b1;
        wb_idx  = 4'd4;
        wb_data = 32'h99;
      end
      #1;
      checks++;
      if (dec_ready_o !== 1'b0 || rf_w_reserve_o !== 1'b0) begin
        errors++;
        $display("FAIL dep_stall%0d: rdy=%b rsv=%b exp 0 0", k, dec_ready_o, rf_w_reserve_o);
      end
      step;
    end
    wb_en = 1'b0;
    #1;
    checks++;
    if (dec_ready_o !== 1'b1 || rf_w_reserve_o !== 1'b1) begin
      errors++;
      $display("FAIL dep_b_fire: rdy=%b rsv=%b exp 1 1", dec_ready_o, rf_w_reserve_o);
    end
    sbq.push_back(mk(OP_SUB, 4'd6, 1'b1, 32'h1006, 32'h99));
    step;
    dec_valid_i = 1'b0;
    if (sbq.size() != 0) e = sbq.pop_front(); else e = '1;
    checks++;
    if (ex_valid_o !== 1'b1 || got !== e) begin
      errors++;
      $display("FAIL dep_b_out: v=%b got=%h exp=%h", ex_valid_o, got, e);
    end
    d = stall_cnt_o - s0;
    checks++;
    if (d !== 16'd4) begin
      errors++;
      $display("FAIL dep_stall_cnt: delta=%0d exp 4", d);
    end
    step;
    wb(4'd6, 32'h66);
  endtask

  task automatic test_backpressure;
    exp_t e;
    logic [15:0] s0;
    ex_ready_i = 1'b0;
    drive(OP_AND, 4'd8, 4'd9, 1'b0, 1'b0, 32'h0);
    #1;
    checks++;
    if (dec_ready_o !== 1'b1 || rf_w_reserve_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_nowe_fire: rdy=%b rsv=%b exp 1 0", dec_ready_o, rf_w_reserve_o);
    end
    sbq.push_back(mk(OP_AND, 4'd8, 1'b0, 32'h1008, 32'h1009));
    step;
    drive(OP_OR, 4'd10, 4'd11, 1'b1, 1'b0, 32'h0);
    s0 = stall_cnt_o;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (dec_ready_o !== 1'b0 || rf_w_reserve_o !== 1'b0 || ex_valid_o !== 1'b1 ||
          got !== sbq[0] || stall_cnt_o !== s0) begin
        errors++;
        $display("FAIL bp_hold%0d: rdy=%b rsv=%b v=%b got=%h exp=%h cnt=%0d exp %0d",
                 k, dec_ready_o, rf_w_reserve_o, ex_valid_o, got, sbq[0], stall_cnt_o, s0);
      end
      step;
    end
    ex_ready_i = 1'b1;
    #1;
    checks++;
    if (dec_ready_o !== 1'b1 || rf_w_reserve_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: rdy=%b rsv=%b exp 1 1", dec_ready_o, rf_w_reserve_o);
    end
    if (sbq.size() != 0) e = sbq.pop_front(); else e = '1;
    checks++;
    if (ex_valid_o !== 1'b1 || got !== e) begin
      errors++;
      $display("FAIL bp_i1_out: v=%b got=%h exp=%h", ex_valid_o, got, e);
    end
    sbq.push_back(mk(OP_OR, 4'd10, 1'b1, 32'h100A, 32'h100B));
    step;
    if (sbq.size() != 0) e = sbq.pop_front(); else e = '1;
    checks++;
    if (ex_valid_o !== 1'b1 || got !== e) begin
      errors++;
      $display("FAIL bp_i2_out: v=%b got=%h exp=%h", ex_valid_o, got, e);
    end
    drive(OP_XOR, 4'd12, 4'd13, 1'b1, 1'b0, 32'h0);
    #1;
    checks++;
    if (dec_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_b2b_fire: rdy=%b exp 1", dec_ready_o);
    end
    sbq.push_back(mk(OP_XOR, 4'd12, 1'b1, 32'h100C, 32'h100D));
    step;
    dec_valid_i = 1'b0;
    if (sbq.size() != 0) e = sbq.pop_front(); else e = '1;
    checks++;
    if (ex_valid_o !== 1'b1 || got !== e) begin
      errors++;
      $display("FAIL bp_i3_out: v=%b got=%h exp=%h", ex_valid_o, got, e);
    end
    step;
    checks++;
    if (ex_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: v=%b exp 0", ex_valid_o);
    end
    wb(4'd10, 32'hAA);
    wb(4'd12, 32'hCC);
  endtask

  task automatic test_reset_mid_full;
    exp_t e;
    ex_ready_i = 1'b0;
    drive(OP_ADD, 4'd1, 4'd2, 1'b1, 1'b0, 32'h0);
    step;
    dec_valid_i = 1'b0;
    #1;
    checks++;
    if (ex_valid_o !== 1'b1 || stall_cnt_o === 16'd0) begin
      errors++;
      $display("FAIL rst_pre: v=%b cnt=%0d exp 1 nonzero", ex_valid_o, stall_cnt_o);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (ex_valid_o !== 1'b0 || stall_cnt_o !== 16'd0 || got !== '0) begin
      errors++;
      $display("FAIL rst_async: v=%b cnt=%0d out=%h exp 0", ex_valid_o, stall_cnt_o, got);
    end
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    step;
    ex_ready_i = 1'b1;
    drive(OP_SUB, 4'd1, 4'd2, 1'b1, 1'b0, 32'h0);
    #1;
    checks++;
    if (dec_ready_o !== 1'b1 || rf_w_reserve_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_first_fire: rdy=%b rsv=%b exp 1 1", dec_ready_o, rf_w_reserve_o);
    end
    sbq.push_back(mk(OP_SUB, 4'd1, 1'b1, 32'h1001, 32'h1002));
    step;
    dec_valid_i = 1'b0;
    if (sbq.size() != 0) e = sbq.pop_front(); else e = '1;
    checks++;
    if (ex_valid_o !== 1'b1 || got !== e) begin
      errors++;
      $display("FAIL rst_first_out: v=%b got=%h exp=%h", ex_valid_o, got, e);
    end
    step;
    wb(4'd1, 32'h11);
  endtask

  task automatic test_saturation;
    exp_t e;
    logic [15:0] s0;
    logic [15:0] d;
    s0 = stall_cnt_o;
    ex_ready_i = 1'b1;
    drive(OP_MOV, 4'd14, 4'd0, 1'b1, 1'b0, 32'h0);
    sbq.push_back(mk(OP_MOV, 4'd14, 1'b1, 32'h100E, 32'h1000));
    step;
    if (sbq.size() != 0) e = sbq.pop_front(); else e = '1;
    checks++;
    if (ex_valid_o !== 1'b1 || got !== e) begin
      errors++;
      $display("FAIL sat_writer_out: v=%b got=%h exp=%h", ex_valid_o, got, e);
    end
    drive(OP_ADD, 4'd14, 4'd15, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 20; k++) step;
    d = stall_cnt_o - s0;
    checks++;
    if (s_cnt !== 4'd15 || d !== 16'd20 || dec_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL sat_20: sat=%0d exp 15 full=%0d exp 20 rdy=%b", s_cnt, d, dec_ready_o);
    end
    step;
    step;
    d = stall_cnt_o - s0;
    checks++;
    if (s_cnt !== 4'd15 || d !== 16'd22) begin
      errors++;
      $display("FAIL sat_hold: sat=%0d exp 15 full=%0d exp 22", s_cnt, d);
    end
    dec_valid_i = 1'b0;
    wb(4'd14, 32'hEE);
  endtask

  initial begin
    test_reset;
    test_add;
    test_imm;
    test_dependent;
    test_backpressure;
    test_reset_mid_full;
    test_saturation;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
